// File: rtl/pe_sram_pkg.sv
// Shared types and helpers for the PE SRAM arbiter.
// The state enum is only exercised when PE_SRAM_ARB_LOCK_EN is defined.
package pe_sram_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int PE_DATA_W = 32;
    localparam int STRB_W    = PE_DATA_W / 8;

    // Index width for n entries; never returns less than 1 so a 2-entry
    // arbiter still gets a real pointer bit.
    function automatic int clog2(input int n);
        int r;
        for (r = 1; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_rr_pick.sv
// Combinational round-robin picker: first eligible index searching upward
// from ptr+1 with wrap-around.
module pe_rr_pick
    import pe_sram_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner,
    output logic          any
);

    logic [IW-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!any && elig[idx]) begin
                any         = 1'b1;
                grant[idx]  = 1'b1;
                winner      = idx;
            end
        end
    end

endmodule

// File: rtl/pe_sram_arb.sv
// Round-robin arbiter sharing one single-port pe_sram between NUM_REQ requesters.
// Define PE_SRAM_ARB_LOCK_EN to add req_lock and the ARB/LOCKED burst FSM.
module pe_sram_arb
    import pe_sram_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int ADR_W    = 12,
    parameter int LOCK_MAX = 16,
    localparam int SW = DATA_W / 8,
    localparam int IW = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*SW-1:0]     req_wstrb,
`ifdef PE_SRAM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      sram_en,
    output logic                      sram_we,
    output logic [ADR_W-1:0]          sram_addr,
    output logic [DATA_W-1:0]         sram_wdata,
    output logic [SW-1:0]             sram_wstrb,
    input  logic [DATA_W-1:0]         sram_rdata,
    output state_t                    dbg_state,
    output logic [IW-1:0]             dbg_rr_ptr
);

    // Handshake: an access is accepted when req_valid[i] & req_ready[i]; it
    // always completes and its response pulses on rsp_valid[i] one cycle later,
    // with no backpressure on either side.

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      winner;
    logic               any;

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

    logic               win_we;
    logic [ADR_W-1:0]   win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic [SW-1:0]      win_wstrb;

`ifdef PE_SRAM_ARB_LOCK_EN
    localparam int CW = clog2(LOCK_MAX + 1);

    state_t         state_q, state_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [CW-1:0]  lock_cnt_q, lock_cnt_d;
    logic           win_lock;

    assign win_lock = req_lock[winner];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            owner_q    <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ARB: begin
                if (any && win_lock && LOCK_MAX > 1) begin
                    state_d    = LOCKED;
                    owner_d    = winner;
                    lock_cnt_d = CW'(1);
                end
            end
            LOCKED: begin
                // Only the owner can win here, so any == an accepted owner beat.
                if (any) begin
                    if (!win_lock || (int'(lock_cnt_q) + 1 >= LOCK_MAX)) begin
                        state_d    = ARB;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        elig = req_valid;
        if (rst) begin
            elig = '0;
        end else if (state_q == LOCKED) begin
            elig = req_valid & (NUM_REQ'(1) << owner_q);
        end
    end

    assign dbg_state = state_q;
`else
    logic unused_lock_max;

    assign unused_lock_max = ^LOCK_MAX;
    assign elig            = rst ? '0 : req_valid;
    assign dbg_state       = ARB;
`endif

    pe_rr_pick #(.N(NUM_REQ)) u_pick (
        .elig   (elig),
        .ptr    (rr_ptr_q),
        .grant  (grant),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        win_we    = req_we[winner];
        win_addr  = req_addr[winner*ADR_W +: ADR_W];
        win_wdata = req_wdata[winner*DATA_W +: DATA_W];
        win_wstrb = req_wstrb[winner*SW +: SW];
    end

    always_comb begin
        req_ready  = grant;
        sram_en    = any;
        sram_we    = any & win_we;
        sram_addr  = any ? win_addr : '0;
        sram_wdata = any ? win_wdata : '0;
        sram_wstrb = (any && win_we) ? win_wstrb : '0;
    end

    // While locked the winner is always the owner, so following the winner
    // leaves rr_ptr at the owner on exit.
    always_comb begin
        rr_ptr_d    = any ? winner : rr_ptr_q;
        rsp_valid_d = grant;
        rsp_rdata_d = (any && !win_we) ? sram_rdata : rsp_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= IW'(NUM_REQ - 1);
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign dbg_rr_ptr = rr_ptr_q;

endmodule
